// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: byte-strobe write side and status/serial outputs of uart_tx_fifo.
//   i_Tx_DV, i_Tx_Byte : write strobe and byte (driven by the master)
//   o_Tx_Ready         : FIFO not full
//   o_Tx_Serial        : 8N1 serial line, idles high
//   o_Tx_Active        : frame in progress
//   o_Tx_Done          : one-cycle pulse after each frame
//   o_Fifo_Count       : bytes queued, excluding the one on the line
interface uart_tx_fifo_if #(
    parameter int unsigned FIFO_DEPTH = 4
);
    localparam int unsigned CountW = $clog2(FIFO_DEPTH) + 1;

    logic              i_Tx_DV;
    logic [7:0]        i_Tx_Byte;
    logic              o_Tx_Ready;
    logic              o_Tx_Serial;
    logic              o_Tx_Active;
    logic              o_Tx_Done;
    logic [CountW-1:0] o_Fifo_Count;

    modport master (
        output i_Tx_DV, i_Tx_Byte,
        input  o_Tx_Ready, o_Tx_Serial, o_Tx_Active, o_Tx_Done, o_Fifo_Count
    );

    modport slave (
        input  i_Tx_DV, i_Tx_Byte,
        output o_Tx_Ready, o_Tx_Serial, o_Tx_Active, o_Tx_Done, o_Fifo_Count
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter fed by a small circular FIFO.
//   i_Clock : system clock, rising edge
//   i_Reset : synchronous, active-low reset
//   tx      : uart_tx_fifo_if slave port (write strobe in, serial/status out)
// CLKS_PER_BIT must be >= 2; FIFO_DEPTH must be a power of 2 and >= 2.
module uart_tx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 87,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input logic         i_Clock,
    input logic         i_Reset,
    uart_tx_fifo_if.slave tx
);
    localparam int unsigned CntW   = $clog2(CLKS_PER_BIT);
    localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CountW = PtrW + 1;

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   clk_cnt_q, clk_cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [7:0]        fifo_mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CountW-1:0] count_q;
    logic              serial_q, serial_d;
    logic              active_q, done_q;
    logic              push, pop, bit_end;

    // A full FIFO drops the write even if a pop frees a slot this cycle.
    assign push    = tx.i_Tx_DV && (count_q < CountW'(FIFO_DEPTH));
    assign bit_end = (clk_cnt_q == CntW'(CLKS_PER_BIT - 1));

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q + CntW'(1);
        bit_idx_d = bit_idx_q;
        tx_data_d = tx_data_q;
        pop       = 1'b0;
        case (state_q)
            StIdle: begin
                clk_cnt_d = '0;
                bit_idx_d = '0;
                if (count_q != '0) begin
                    pop       = 1'b1;
                    tx_data_d = fifo_mem_q[rd_ptr_q];
                    state_d   = StStart;
                end
            end
            StStart: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    state_d   = StData;
                end
            end
            StData: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            StStop: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    state_d   = StIdle;
                end
            end
            default: begin
                clk_cnt_d = '0;
                state_d   = StIdle;
            end
        endcase
    end

    // Line level for the current state; registered below so the pin never glitches.
    always_comb begin
        serial_d = 1'b1;
        case (state_q)
            StStart: serial_d = 1'b0;
            StData:  serial_d = tx_data_q[bit_idx_q];
            default: serial_d = 1'b1;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Reset) begin
            state_q   <= StIdle;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            tx_data_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            serial_q  <= 1'b1;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            tx_data_q <= tx_data_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CountW'(1);
            end else if (!push && pop) begin
                count_q <= count_q - CountW'(1);
            end
            serial_q <= serial_d;
            // Outputs trail the FSM by one cycle, so active_q still shows the
            // stop bit during the first FSM idle cycle; that is the only way
            // state_q can be idle with active_q high, and it marks frame end.
            active_q <= (state_q != StIdle);
            done_q   <= (state_q == StIdle) && active_q;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset && push) begin
            fifo_mem_q[wr_ptr_q] <= tx.i_Tx_Byte;
        end
    end

    assign tx.o_Tx_Ready   = (count_q < CountW'(FIFO_DEPTH));
    assign tx.o_Fifo_Count = count_q;
    assign tx.o_Tx_Serial  = serial_q;
    assign tx.o_Tx_Active  = active_q;
    assign tx.o_Tx_Done    = done_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;
    localparam int unsigned C = 87;
    localparam int unsigned D = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    uart_tx_fifo_if #(.FIFO_DEPTH(D)) tx_if ();

    uart_tx_fifo #(
        .CLKS_PER_BIT(C),
        .FIFO_DEPTH  (D)
    ) dut (
        .i_Clock(clk),
        .i_Reset(rst_n),
        .tx     (tx_if)
    );

    always #5 clk = ~clk;

    int unsigned n_total = 0;
    int unsigned n_pass = 0;
    int unsigned done_pulses = 0;
    int unsigned rst_events = 0;
    int unsigned frame_errs = 0;
    int unsigned exp_frames = 0;
    int unsigned rx_rd = 0;
    logic [7:0]  rx_q [$];
    logic [7:0]  exp_q [$];

    always @(posedge clk) begin
        if (tx_if.o_Tx_Done === 1'b1) done_pulses <= done_pulses + 1;
        if (rst_n === 1'b0) rst_events <= rst_events + 1;
    end

    // Behavioural receiver: mid-bit sampling of the line; frames cut by reset are discarded.
    initial begin
        logic [7:0]  b;
        logic        stop;
        int unsigned r0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx_if.o_Tx_Serial === 1'b0) begin
                r0 = rst_events;
                repeat (C / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (C) @(negedge clk);
                    b[i] = tx_if.o_Tx_Serial;
                end
                repeat (C) @(negedge clk);
                stop = tx_if.o_Tx_Serial;
                if (rst_events == r0) begin
                    rx_q.push_back(b);
                    if (stop !== 1'b1) frame_errs++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic push(input logic [7:0] b);
        tx_if.i_Tx_DV   = 1'b1;
        tx_if.i_Tx_Byte = b;
        tick();
        tx_if.i_Tx_DV   = 1'b0;
    endtask

    task automatic expect_byte(input logic [7:0] b);
        exp_q.push_back(b);
        exp_frames++;
    endtask

    // Wait for the transmitter to go quiet, then compare decoded frames with the model.
    task automatic drain(input string tag);
        int unsigned quiet = 0;
        int unsigned n = 0;
        while (quiet < 3 && n < 12 * C * (D + 2)) begin
            tick();
            n++;
            if (tx_if.o_Fifo_Count == '0 && tx_if.o_Tx_Active == 1'b0) quiet++;
            else quiet = 0;
        end
        chk({tag, "_drained"}, 32'(quiet >= 3), 32'd1);
        chk({tag, "_frames"}, 32'(rx_q.size() - rx_rd), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && (rx_rd + i) < rx_q.size(); i++) begin
            chk($sformatf("%s_byte%0d", tag, i), 32'(rx_q[rx_rd + i]), 32'(exp_q[i]));
        end
        chk({tag, "_stop_bits"}, frame_errs, 32'd0);
        rx_rd = rx_q.size();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0]  sb;
        logic [7:0]  lb [4];
        logic [7:0]  v;
        logic        expb;
        int unsigned good;
        int unsigned d0;
        int unsigned n;
        int unsigned waited;

        sb = 8'hA5;
        lb = '{8'h00, 8'hFF, 8'h3C, 8'h81};

        // Reset with a write strobe held high: the strobe must be ignored.
        tx_if.i_Tx_DV   = 1'b1;
        tx_if.i_Tx_Byte = 8'h55;
        repeat (3) tick();
        chk("rst_serial", 32'(tx_if.o_Tx_Serial), 32'd1);
        chk("rst_active", 32'(tx_if.o_Tx_Active), 32'd0);
        chk("rst_done", 32'(tx_if.o_Tx_Done), 32'd0);
        chk("rst_ready", 32'(tx_if.o_Tx_Ready), 32'd1);
        chk("rst_count", 32'(tx_if.o_Fifo_Count), 32'd0);
        tx_if.i_Tx_DV = 1'b0;
        rst_n = 1'b1;
        repeat (3) tick();
        chk("post_rst_count", 32'(tx_if.o_Fifo_Count), 32'd0);
        chk("post_rst_active", 32'(tx_if.o_Tx_Active), 32'd0);

        // Single byte with exact cycle timing.
        push(sb);
        expect_byte(sb);
        chk("sb_count1", 32'(tx_if.o_Fifo_Count), 32'd1);
        chk("sb_line_idle", 32'(tx_if.o_Tx_Serial), 32'd1);
        tick();
        chk("sb_popped", 32'(tx_if.o_Fifo_Count), 32'd0);
        chk("sb_line_pre", 32'(tx_if.o_Tx_Serial), 32'd1);
        chk("sb_active_pre", 32'(tx_if.o_Tx_Active), 32'd0);
        tick();
        for (int b = 0; b < 10; b++) begin
            expb = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : sb[b - 1];
            good = 0;
            for (int c = 0; c < int'(C); c++) begin
                if (tx_if.o_Tx_Serial === expb && tx_if.o_Tx_Active === 1'b1 &&
                    tx_if.o_Tx_Done === 1'b0) good++;
                tick();
            end
            chk($sformatf("sb_bit%0d_cycles", b), good, C);
        end
        chk("sb_done", 32'(tx_if.o_Tx_Done), 32'd1);
        chk("sb_done_active", 32'(tx_if.o_Tx_Active), 32'd0);
        chk("sb_done_line", 32'(tx_if.o_Tx_Serial), 32'd1);
        chk("sb_done_count", 32'(tx_if.o_Fifo_Count), 32'd0);
        tick();
        chk("sb_done_pulse_len", 32'(tx_if.o_Tx_Done), 32'd0);
        drain("single");

        // Loopback of the four reference bytes.
        d0 = done_pulses;
        for (int i = 0; i < 4; i++) begin
            push(lb[i]);
            expect_byte(lb[i]);
        end
        drain("loop");
        chk("loop_done_pulses", done_pulses - d0, 32'd4);

        // Overflow: six consecutive writes from idle; first pops at once, sixth drops.
        for (int i = 0; i < 6; i++) begin
            v = 8'($urandom);
            push(v);
            if (i < 5) expect_byte(v);
            if (i == 4) begin
                chk("ov_full_count", 32'(tx_if.o_Fifo_Count), D);
                chk("ov_full_ready", 32'(tx_if.o_Tx_Ready), 32'd0);
            end
        end
        chk("ov_drop_count", 32'(tx_if.o_Fifo_Count), D);
        drain("ovf");

        // Random bursts from idle: at most D+1 bytes of a back-to-back burst survive.
        for (int k = 0; k < 3; k++) begin
            n = $urandom_range(1, 7);
            for (int i = 0; i < int'(n); i++) begin
                v = 8'($urandom);
                push(v);
                if (i < int'(D) + 1) expect_byte(v);
            end
            drain($sformatf("burst%0d", k));
        end

        // Push in the same cycle as the idle pop that follows a frame.
        for (int i = 0; i < 3; i++) begin
            v = 8'($urandom);
            push(v);
            expect_byte(v);
        end
        chk("sim_count2", 32'(tx_if.o_Fifo_Count), 32'd2);
        repeat (10 * C - 1) tick();
        v = 8'($urandom);
        tx_if.i_Tx_DV   = 1'b1;
        tx_if.i_Tx_Byte = v;
        tick();
        tx_if.i_Tx_DV = 1'b0;
        expect_byte(v);
        chk("sim_done", 32'(tx_if.o_Tx_Done), 32'd1);
        chk("sim_count_held", 32'(tx_if.o_Fifo_Count), 32'd2);
        drain("simul");

        // Reset during data bit 3 with two bytes queued.
        for (int i = 0; i < 3; i++) push(8'($urandom));
        repeat (4 * C + C / 2) tick();
        chk("rm_in_frame", 32'(tx_if.o_Tx_Active), 32'd1);
        chk("rm_queued", 32'(tx_if.o_Fifo_Count), 32'd2);
        rst_n = 1'b0;
        tx_if.i_Tx_DV   = 1'b1;
        tx_if.i_Tx_Byte = 8'hC3;
        tick();
        chk("rm_line", 32'(tx_if.o_Tx_Serial), 32'd1);
        chk("rm_active", 32'(tx_if.o_Tx_Active), 32'd0);
        chk("rm_count", 32'(tx_if.o_Fifo_Count), 32'd0);
        chk("rm_ready", 32'(tx_if.o_Tx_Ready), 32'd1);
        chk("rm_done", 32'(tx_if.o_Tx_Done), 32'd0);
        rst_n = 1'b1;
        tx_if.i_Tx_DV = 1'b0;
        good = 0;
        for (int c = 0; c < int'(12 * C); c++) begin
            if (tx_if.o_Tx_Serial === 1'b1 && tx_if.o_Tx_Active === 1'b0 &&
                tx_if.o_Tx_Done === 1'b0) good++;
            tick();
        end
        chk("rm_line_stays_high", good, 12 * C);
        drain("rstmid");

        // Stream 0x01..0x0A with random gaps, never letting the FIFO fill.
        for (int i = 1; i <= 10; i++) begin
            waited = 0;
            while (tx_if.o_Fifo_Count >= 3 && waited < 12 * C) begin
                tick();
                waited++;
            end
            repeat ($urandom_range(0, 15)) tick();
            chk($sformatf("wrap_ready%0d", i), 32'(tx_if.o_Tx_Ready), 32'd1);
            push(8'(i));
            expect_byte(8'(i));
        end
        drain("wrap");

        chk("done_total", done_pulses, exp_frames);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

UART transmitter with a small transmit FIFO: accepts bytes on a strobe interface and serialises them as 8N1 frames (1 start, 8 data LSB first, 1 stop) on `o_Tx_Serial`. It is the transmit-side counterpart to the SoC's UART receiver and runs at the same `CLKS_PER_BIT` so a TX→RX loopback is bit-exact. The FIFO lets software or a bus bridge queue several bytes without waiting for each frame to finish.

## Interface
- `CLKS_PER_BIT`, default 87: clock cycles per bit period; must be ≥ 2.
- `FIFO_DEPTH`, default 4: number of FIFO entries; must be a power of 2 and ≥ 2.
- `i_Clock`  input  1  system clock; all logic is on the rising edge.
- `i_Reset`  input  1  reset; synchronous, active-low.
- `i_Tx_DV`  input  1  write strobe; `i_Tx_Byte` is pushed when `i_Tx_DV && o_Tx_Ready`.
- `i_Tx_Byte`  input  8  byte to enqueue.
- `o_Tx_Ready`  output  1  FIFO not full (`count < FIFO_DEPTH`).
- `o_Tx_Serial`  output  1  serial line; idles high.
- `o_Tx_Active`  output  1  high while in START, DATA or STOP.
- `o_Tx_Done`  output  1  single-cycle pulse after each frame's stop bit completes.
- `o_Fifo_Count`  output  $clog2(FIFO_DEPTH)+1  number of bytes currently queued. This does not include the byte being transmitted.

## Operation
- **FIFO**
  - Circular buffer with read/write pointers of width $clog2(FIFO_DEPTH). Pointers wrap modulo depth.
  - A push occurs when `i_Tx_DV && o_Tx_Ready`.
  - A push while full is silently dropped. This holds even if a pop happens in the same cycle.
  - A simultaneous push and pop on a non-full FIFO leaves the count unchanged.
  - A pop occurs only from IDLE when the count is > 0. The popped byte is loaded into the shift register `r_Tx_Data`.
- **FSM states**
  - IDLE: line high. If the count is > 0, pop and go to START.
  - START: line low for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: line = `r_Tx_Data[bit_index]` for CLKS_PER_BIT cycles per bit. After bit 7's period, go to STOP.
  - STOP: line high for CLKS_PER_BIT cycles. In its final cycle, set `o_Tx_Done` for the next cycle and go to IDLE.
  - Any unused encoding goes to IDLE.
- **Counters**
  - The clock counter has width $clog2(CLKS_PER_BIT). It resets to 0 on every state or bit change and counts 0..CLKS_PER_BIT−1.
  - The bit index is 3 bits.
- **Output generation**
  - `o_Tx_Serial` is registered and driven from the state and current bit, with no combinational glitch path.
  - `o_Tx_Ready` and `o_Fifo_Count` are derived from the registered count.
- **Reset (`i_Reset` low at a clock edge)**
  - FSM goes to IDLE.
  - FIFO is flushed: pointers and count = 0.
  - Counters = 0.
  - `o_Tx_Serial` = 1, `o_Tx_Active` = 0, `o_Tx_Done` = 0, `o_Tx_Ready` = 1, `o_Fifo_Count` = 0.
  - A frame in progress is aborted; the line is high from that edge.
  - `i_Tx_DV` is ignored during reset.

## Timing
- **Push to line low:** push at edge N on an empty FIFO in IDLE → count = 1 after N. Pop at edge N+1. `o_Tx_Serial` = 0 and `o_Tx_Active` = 1 from edge N+2.
- **Frame:** start, 8 data bits, stop; each bit lasts exactly CLKS_PER_BIT cycles, 10×CLKS_PER_BIT cycles in total.
- **`o_Tx_Done`:** high for exactly one cycle, the first cycle back in IDLE. `o_Tx_Active` is 0 in that cycle.
- **Back-to-back frames:** there is exactly one IDLE cycle (line high) between stop and the next start. The effective stop bit is therefore CLKS_PER_BIT+1 cycles.
- **Pop during IDLE:** the pop in that cycle decrements the count in the same cycle as the Done pulse, if queued.
- **Writes during transmission:** accepted freely up to FIFO_DEPTH. `o_Tx_Ready` drops in the cycle after the count reaches FIFO_DEPTH and rises the cycle after a pop.

## Test plan
- **Single byte:** reset, then push 0xA5 → line low at push+2. Line shows 1,0,1,0,0,1,0,1 (LSB first), then stop high. Each bit lasts 87 cycles. One `o_Tx_Done` pulse, count back to 0.
- **Loopback:** connect `o_Tx_Serial` to the UART receiver. Push 0x00, 0xFF, 0x3C, 0x81 → receiver delivers the identical 4 bytes in order.
- **Overflow (FIFO_DEPTH=4):** push 6 bytes on consecutive cycles from idle.
  - The first is popped immediately.
  - Bytes 2–5 fill the FIFO; `o_Tx_Ready`=0, count=4.
  - Byte 6 is dropped.
  - Exactly 5 frames are emitted.
- **Simultaneous push/pop:** with count=2, push exactly in the IDLE pop cycle after a Done → count stays 2. Frame order is preserved.
- **Reset mid-frame:** assert `i_Reset` low during data bit 3 with 2 bytes queued.
  - After the next edge: line=1, Active=0, count=0, Ready=1, no Done pulse.
  - After release with no further pushes, the line stays high.
- **Pointer wrap:** stream 10 bytes (0x01..0x0A), keeping the FIFO non-full → all 10 frames are correct and in order, covering at least two wrap-arounds of the pointers.
